// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream fan-out demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    DEMUX_RR   = 1'b0,
    DEMUX_ADDR = 1'b1
  } demux_mode_e;

  // Increment with explicit wrap so non-power-of-2 channel counts work.
  function automatic int unsigned next_ch(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register; a drain and a load in the same
// cycle replaces the entry without a bubble.
module demux_slot #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_fanout_demux.sv
// Fans one valid/ready stream out to NUM_OUTS one-entry channels, round-robin or addressed.
// Build option STREAM_DEMUX_SKIP_BUSY_EN: round-robin skips busy slots instead of stalling.
module stream_fanout_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_OUTS = 8,
  parameter  int DATA_W   = 1,
  localparam int CNT_W    = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  demux_mode_e                mode,
  input  logic [CNT_W-1:0]           in_sel,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUTS*DATA_W-1:0] out_data,
  output logic [NUM_OUTS-1:0]        out_valid,
  input  logic [NUM_OUTS-1:0]        out_ready,
  output logic [CNT_W-1:0]           cur_ch,
  output logic                       sel_err
);

  logic [CNT_W-1:0]    r_cur_ch;
  logic                r_sel_err;
  logic [NUM_OUTS-1:0] w_free;
  logic [NUM_OUTS-1:0] w_load;
  logic [NUM_OUTS-1:0] w_vld;
  logic [DATA_W-1:0]   w_dat [NUM_OUTS];
  logic [CNT_W-1:0]    w_tgt;
  logic                w_oob;
  logic                w_rr_rdy;
  logic                w_acc;

  assign w_free = ~w_vld | out_ready;
  assign w_oob  = (mode == DEMUX_ADDR) && ({1'b0, in_sel} >= (CNT_W + 1)'(NUM_OUTS));

  always_comb begin
    logic [CNT_W-1:0] c;
    logic             hit;
    w_tgt    = r_cur_ch;
    w_rr_rdy = w_free[r_cur_ch];
    c        = r_cur_ch;
    hit      = w_free[r_cur_ch];
`ifdef STREAM_DEMUX_SKIP_BUSY_EN
    // Rotating search starting just past the pointer for the first free slot.
    for (int i = 1; i < NUM_OUTS; i++) begin
      c = CNT_W'(next_ch(int'(c), NUM_OUTS));
      if (!hit && w_free[c]) begin
        w_tgt = c;
        hit   = 1'b1;
      end
    end
    w_rr_rdy = |w_free;
`endif
    if (mode == DEMUX_ADDR) w_tgt = in_sel;
  end

  assign in_ready = (mode == DEMUX_ADDR) ? (w_oob | w_free[in_sel]) : w_rr_rdy;
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_ch  <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_acc & w_oob;
      if (w_acc && mode == DEMUX_RR) r_cur_ch <= CNT_W'(next_ch(int'(w_tgt), NUM_OUTS));
    end
  end

  for (genvar k = 0; k < NUM_OUTS; k++) begin : g_slot
    assign w_load[k] = w_acc & ~w_oob & (w_tgt == CNT_W'(k));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (w_vld[k]),
      .o_data  (w_dat[k])
    );

    assign out_data[k*DATA_W +: DATA_W] = w_dat[k];
  end

  assign out_valid = w_vld;
  assign cur_ch    = r_cur_ch;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_fanout_demux.sv
// Directed bench for stream_fanout_demux with NUM_OUTS=5, DATA_W=8.
module tb_stream_fanout_demux;
  import stream_demux_pkg::*;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  demux_mode_e   mode;
  logic [CW-1:0] in_sel;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [CW-1:0] cur_ch;
  logic          sel_err;

  int n_chk = 0;
  int n_err = 0;

  stream_fanout_demux #(.NUM_OUTS(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_ch    (cur_ch),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] chd(input int k);
    return out_data[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    mode      = DEMUX_RR;
    in_sel    = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_cur", 64'(cur_ch), 64'(0));
    chk("rst_err", 64'(sel_err), 64'(0));
    tick();

    // Round-robin with all sinks ready.
    out_ready = '1;
    mode      = DEMUX_RR;
    for (int i = 0; i < 12; i++) begin
      in_data  = DW'(i);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_rdy%0d", i), 64'(in_ready), 64'(1));
      chk($sformatf("rr_cur%0d", i), 64'(cur_ch), 64'(i % N));
      tick();
      chk($sformatf("rr_vld%0d", i), 64'(out_valid), 64'(1 << (i % N)));
      chk($sformatf("rr_dat%0d", i), 64'(chd(i % N)), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("rr_drained", 64'(out_valid), 64'(0));
    chk("rr_cur_end", 64'(cur_ch), 64'(2));

    // Addressed back-pressure on ch3; pointer must hold at 2.
    mode         = DEMUX_ADDR;
    in_sel       = 3'd3;
    out_ready[3] = 1'b0;
    in_data      = 8'h31;
    in_valid     = 1'b1;
    @(negedge clk);
    chk("ad_rdy1", 64'(in_ready), 64'(1));
    tick();
    in_data = 8'h32;
    @(negedge clk);
    chk("ad_stall1", 64'(in_ready), 64'(0));
    chk("ad_hold1", 64'(chd(3)), 64'h31);
    tick();
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk("ad_rdy2", 64'(in_ready), 64'(1));
    tick();
    chk("ad_dat2", 64'(chd(3)), 64'h32);
    out_ready[3] = 1'b0;
    in_data      = 8'h33;
    @(negedge clk);
    chk("ad_stall3", 64'(in_ready), 64'(0));
    chk("ad_hold3", 64'(chd(3)), 64'h32);
    tick();
    out_ready[3] = 1'b1;
    tick();
    chk("ad_dat3", 64'(chd(3)), 64'h33);
    chk("ad_vld3", 64'(out_valid), 64'h08);
    in_valid = 1'b0;
    tick();
    chk("ad_drained", 64'(out_valid), 64'(0));
    chk("ad_cur", 64'(cur_ch), 64'(2));

    // Out-of-range addresses 6 and 5 are swallowed with a one-cycle error pulse.
    in_sel   = 3'd6;
    in_data  = 8'hEE;
    in_valid = 1'b1;
    @(negedge clk);
    chk("oob_rdy", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("oob_err", 64'(sel_err), 64'(1));
    chk("oob_vld", 64'(out_valid), 64'(0));
    tick();
    chk("oob_err_off", 64'(sel_err), 64'(0));
    in_sel   = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("oob5_err", 64'(sel_err), 64'(1));
    chk("oob5_vld", 64'(out_valid), 64'(0));
    tick();
    chk("oob5_err_off", 64'(sel_err), 64'(0));
    chk("oob_cur", 64'(cur_ch), 64'(2));

    // Reset discards held entries.
    do_reset();
    mode      = DEMUX_RR;
    out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_data  = DW'(8'h50 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("fill_vld", 64'(out_valid), 64'h0F);
    chk("fill_d3", 64'(chd(3)), 64'h53);
    chk("fill_cur", 64'(cur_ch), 64'(4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 64'(out_valid), 64'(0));
    chk("mid_rst_dat", 64'(out_data), 64'(0));
    chk("mid_rst_cur", 64'(cur_ch), 64'(0));

    // Busy slot in round-robin: ch2 pre-filled by address while its sink is stalled.
    out_ready = 5'b11011;
    mode      = DEMUX_ADDR;
    in_sel    = 3'd2;
    in_data   = 8'h22;
    in_valid  = 1'b1;
    tick();
    mode    = DEMUX_RR;
    in_data = 8'hB0;
    tick();
    in_data = 8'hB1;
    tick();
    chk("bz_d1", 64'(chd(1)), 64'hB1);
    in_data = 8'hB2;
    @(negedge clk);
    chk("bz_cur", 64'(cur_ch), 64'(2));
`ifdef STREAM_DEMUX_SKIP_BUSY_EN
    chk("bz_rdy", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("bz_d3", 64'(chd(3)), 64'hB2);
    chk("bz_d2_held", 64'(chd(2)), 64'h22);
    chk("bz_cur_after", 64'(cur_ch), 64'(4));
    out_ready[2] = 1'b1;
    tick();
`else
    chk("bz_rdy", 64'(in_ready), 64'(0));
    tick();
    tick();
    chk("bz_stall", 64'(in_ready), 64'(0));
    chk("bz_d2_held", 64'(chd(2)), 64'h22);
    out_ready[2] = 1'b1;
    @(negedge clk);
    chk("bz_release", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("bz_d2", 64'(chd(2)), 64'hB2);
    chk("bz_vld2", 64'(out_valid[2]), 64'(1));
    chk("bz_cur_after", 64'(cur_ch), 64'(3));
    tick();
`endif

    // Same-cycle drain and load on ch1: no bubble, no lost byte.
    out_ready = '1;
    tick();
    out_ready[1] = 1'b0;
    mode         = DEMUX_ADDR;
    in_sel       = 3'd1;
    in_data      = 8'h61;
    in_valid     = 1'b1;
    tick();
    chk("dl_d1", 64'(chd(1)), 64'h61);
    out_ready[1] = 1'b1;
    in_data      = 8'h62;
    @(negedge clk);
    chk("dl_rdy", 64'(in_ready), 64'(1));
    tick();
    chk("dl_d2", 64'(chd(1)), 64'h62);
    chk("dl_v2", 64'(out_valid), 64'h02);
    in_data = 8'h63;
    tick();
    in_valid = 1'b0;
    chk("dl_d3", 64'(chd(1)), 64'h63);
    chk("dl_v3", 64'(out_valid), 64'h02);
    tick();
    chk("dl_drained", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
